// File: rtl/inst_encoder.sv
// -----------------------------------------------------------------------------
// inst_encoder
//
// Purpose:
//   Inverse of the ID-stage decoder. Takes a decoded operation description
//   (aluop/alusel, operand form, register addresses, immediate) over a
//   valid/ready handshake, builds the 32-bit MIPS instruction word and queues
//   it in a small circular FIFO that feeds the instruction-injection path
//   (debug / self-test loader driving the IF/ID instruction bus).
//
// Parameters:
//   DEPTH  FIFO entries, power of two in 2..16
//   CNT_W  width of count_o, wide enough to hold DEPTH
//
// Ports:
//   clk           clock, all state changes on the rising edge
//   rst           asynchronous active-low reset
//   flush_i       synchronous FIFO clear (drops any concurrent push/pop)
//   req_valid_i   request valid
//   req_ready_o   encoder can accept a request (!full & !flush_i, low in reset)
//   aluop_i       ALU op code (shared define set)
//   alusel_i      result class: NOP / LOGIC / SHIFT
//   form_i        operand form: 0 reg-reg, 1 zext imm16, 2 lui, 3 shift amount
//   src1_i        rs address
//   src2_i        rt source address
//   dst_i         destination register address
//   imm_i         immediate, [4:0] is the shift amount in form 3
//   inst_o        head-of-FIFO instruction word (0 when empty)
//   inst_valid_o  inst_o valid
//   inst_ready_i  consumer takes inst_o
//   count_o       FIFO occupancy
//   err_o         one-cycle pulse the cycle after a rejected request
//
// Build option:
//   INST_ENC_ZERO_DST_CHECK_EN  when defined, every non-NOP request with
//                               dst_i == 0 is rejected as illegal.
// -----------------------------------------------------------------------------
module inst_encoder #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [7:0]       aluop_i,
  input  logic [2:0]       alusel_i,
  input  logic [1:0]       form_i,
  input  logic [4:0]       src1_i,
  input  logic [4:0]       src2_i,
  input  logic [4:0]       dst_i,
  input  logic [15:0]      imm_i,
  output logic [31:0]      inst_o,
  output logic             inst_valid_o,
  input  logic             inst_ready_i,
  output logic [CNT_W-1:0] count_o,
  output logic             err_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // ALU op codes
  localparam logic [7:0] ALUOP_AND = 8'b0010_0100;
  localparam logic [7:0] ALUOP_OR  = 8'b0010_0101;
  localparam logic [7:0] ALUOP_XOR = 8'b0010_0110;
  localparam logic [7:0] ALUOP_NOR = 8'b0010_0111;
  localparam logic [7:0] ALUOP_SLL = 8'b0111_1100;
  localparam logic [7:0] ALUOP_SRL = 8'b0000_0010;
  localparam logic [7:0] ALUOP_SRA = 8'b0000_0011;

  // Result classes
  localparam logic [2:0] SEL_NOP   = 3'b000;
  localparam logic [2:0] SEL_LOGIC = 3'b001;
  localparam logic [2:0] SEL_SHIFT = 3'b100;

  // Operand forms
  localparam logic [1:0] FORM_RR  = 2'd0;
  localparam logic [1:0] FORM_IMM = 2'd1;
  localparam logic [1:0] FORM_LUI = 2'd2;
  localparam logic [1:0] FORM_SA  = 2'd3;

  // Major opcodes (I-type) and R-type function codes
  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_ANDI    = 6'b001100;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_XORI    = 6'b001110;
  localparam logic [5:0] OP_LUI     = 6'b001111;

  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_SRLV = 6'b000110;
  localparam logic [5:0] FN_SRAV = 6'b000111;
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;

  // R-type word: SPECIAL / rs / rt / rd / sa / funct
  function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] sa,
                                         input logic [5:0] funct);
    r_type = {OP_SPECIAL, rs, rt, rd, sa, funct};
  endfunction

  // I-type word: op / rs / rt / imm16
  function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    i_type = {op, rs, rt, imm};
  endfunction

  // FIFO state
  logic [31:0]      r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_err;

  // Encoder / handshake wires
  logic        w_enc_ok;
  logic [31:0] w_word;
  logic        w_dst_ok;
  logic        w_legal;
  logic        w_full;
  logic        w_empty;
  logic        w_accept;
  logic        w_push;
  logic        w_pop;

  // Encode the request and flag whether the aluop/alusel/form combination is listed
  always_comb begin
    w_enc_ok = 1'b0;
    w_word   = 32'h0000_0000;
    case (alusel_i)
      SEL_NOP: begin
        // The NOP class only exists in reg-reg form; its word is all zeros.
        if (form_i == FORM_RR) begin
          w_enc_ok = 1'b1;
        end else begin
          w_enc_ok = 1'b0;
        end
      end
      SEL_LOGIC: begin
        case (form_i)
          FORM_RR: begin
            w_enc_ok = 1'b1;
            case (aluop_i)
              ALUOP_AND: w_word = r_type(src1_i, src2_i, dst_i, 5'd0, FN_AND);
              ALUOP_OR:  w_word = r_type(src1_i, src2_i, dst_i, 5'd0, FN_OR);
              ALUOP_XOR: w_word = r_type(src1_i, src2_i, dst_i, 5'd0, FN_XOR);
              ALUOP_NOR: w_word = r_type(src1_i, src2_i, dst_i, 5'd0, FN_NOR);
              default:   w_enc_ok = 1'b0;
            endcase
          end
          FORM_IMM: begin
            // No NORI exists in the ISA, so NOR has no immediate form.
            w_enc_ok = 1'b1;
            case (aluop_i)
              ALUOP_AND: w_word = i_type(OP_ANDI, src1_i, dst_i, imm_i);
              ALUOP_OR:  w_word = i_type(OP_ORI,  src1_i, dst_i, imm_i);
              ALUOP_XOR: w_word = i_type(OP_XORI, src1_i, dst_i, imm_i);
              default:   w_enc_ok = 1'b0;
            endcase
          end
          FORM_LUI: begin
            // The decoder maps lui onto OR with a high immediate; rs is zero.
            if (aluop_i == ALUOP_OR) begin
              w_enc_ok = 1'b1;
              w_word   = i_type(OP_LUI, 5'd0, dst_i, imm_i);
            end else begin
              w_enc_ok = 1'b0;
            end
          end
          default: w_enc_ok = 1'b0;
        endcase
      end
      SEL_SHIFT: begin
        case (form_i)
          FORM_RR: begin
            // Variable shifts: amount comes from rs.
            w_enc_ok = 1'b1;
            case (aluop_i)
              ALUOP_SLL: w_word = r_type(src1_i, src2_i, dst_i, 5'd0, FN_SLLV);
              ALUOP_SRL: w_word = r_type(src1_i, src2_i, dst_i, 5'd0, FN_SRLV);
              ALUOP_SRA: w_word = r_type(src1_i, src2_i, dst_i, 5'd0, FN_SRAV);
              default:   w_enc_ok = 1'b0;
            endcase
          end
          FORM_SA: begin
            // Constant shifts: rs is zero, amount in the sa field.
            w_enc_ok = 1'b1;
            case (aluop_i)
              ALUOP_SLL: w_word = r_type(5'd0, src2_i, dst_i, imm_i[4:0], FN_SLL);
              ALUOP_SRL: w_word = r_type(5'd0, src2_i, dst_i, imm_i[4:0], FN_SRL);
              ALUOP_SRA: w_word = r_type(5'd0, src2_i, dst_i, imm_i[4:0], FN_SRA);
              default:   w_enc_ok = 1'b0;
            endcase
          end
          default: w_enc_ok = 1'b0;
        endcase
      end
      default: begin
        w_enc_ok = 1'b0;
        w_word   = 32'h0000_0000;
      end
    endcase
  end

`ifdef INST_ENC_ZERO_DST_CHECK_EN
  // Writing r0 is a no-op on MIPS; reject it for anything but an explicit NOP.
  assign w_dst_ok = (alusel_i == SEL_NOP) || (dst_i != 5'd0);
`else
  assign w_dst_ok = 1'b1;
`endif

  assign w_legal = w_enc_ok & w_dst_ok;

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == {CNT_W{1'b0}});

  // Ready is gated by rst so it drops the instant reset asserts, not at the next edge.
  assign req_ready_o = rst & ~w_full & ~flush_i;
  assign w_accept    = req_valid_i & req_ready_o;
  // An illegal request still completes its handshake but is never stored.
  assign w_push      = w_accept & w_legal;
  assign w_pop       = ~w_empty & inst_ready_i & ~flush_i;

  // FIFO storage, pointers and occupancy; flush wins over any push or pop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 32'h0000_0000;
      end
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {CNT_W{1'b0}};
    end else if (flush_i) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {CNT_W{1'b0}};
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_word;
        // DEPTH is a power of two, so the natural pointer overflow is the wrap.
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end else begin
        r_wr_ptr <= r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end else begin
        r_rd_ptr <= r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Rejection flag, visible the cycle after the handshake
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_accept & ~w_legal;
    end
  end

  // All outputs come straight from state registers; there is no request-to-output path.
  assign inst_valid_o = ~w_empty;
  assign inst_o       = w_empty ? 32'h0000_0000 : r_mem[r_rd_ptr];
  assign count_o      = r_count;
  assign err_o        = r_err;

endmodule

// File: doc/inst_encoder.md
Name: inst_encoder

Overview:
- Instruction encoder: the inverse of the ID-stage decoder.
- Accepts a decoded operation description (aluop/alusel, operand form, register addresses, immediate) over a valid/ready handshake.
- Produces the 32-bit MIPS instruction word and buffers it in a small FIFO.
- Feeds the instruction-injection path (debug/self-test loader) that drives the IF/ID instruction bus.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- CNT_W, 3, width of count_o; must hold DEPTH.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; one clock; reset is asynchronous and active-low.
- flush_i  in  1  synchronous FIFO clear.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  encoder can accept a request.
- aluop_i  in  8  ALU op code from the shared define set: NOP=00000000, AND=00100100, OR=00100101, XOR=00100110, NOR=00100111, SLL=01111100, SRL=00000010, SRA=00000011.
- alusel_i  in  3  result class: NOP=000, LOGIC=001, SHIFT=100.
- form_i  in  2  operand form: 0 reg-reg, 1 zero-extended imm16 low, 2 imm16 high (lui), 3 shift-amount.
- src1_i  in  5  rs address.
- src2_i  in  5  rt source address.
- dst_i  in  5  destination register address.
- imm_i  in  16  immediate; bits [4:0] are the shift amount in form 3.
- inst_o  out  32  head-of-FIFO instruction word.
- inst_valid_o  out  1  inst_o valid.
- inst_ready_i  in  1  consumer takes inst_o.
- count_o  out  CNT_W  FIFO occupancy.
- err_o  out  1  one-cycle pulse: request rejected.

Behaviour:
- Accept when req_valid_i & req_ready_o; req_ready_o = !full & !flush_i.
- Encoding of an accepted request (op / rs / rt / rd / sa / funct):
  - NOP class: 32'h00000000.
  - LOGIC form 0: 000000 / src1 / src2 / dst / 0 / funct. Funct: AND 100100, OR 100101, XOR 100110, NOR 100111.
  - LOGIC form 1: op / src1 / dst / imm. Op: ANDI 001100, ORI 001101, XORI 001110. NOR is illegal.
  - LOGIC form 2, OR only: 001111 / 00000 / dst / imm (lui). Any other aluop is illegal.
  - SHIFT form 0: 000000 / src1 / src2 / dst / 0 / funct. Funct: SLLV 000100, SRLV 000110, SRAV 000111.
  - SHIFT form 3: 000000 / 00000 / src2 / dst / imm[4:0] / funct. Funct: SLL 000000, SRL 000010, SRA 000011.
- Illegal request: any aluop/alusel/form combination not listed above (including NOP with a nonzero form).
  - Handshake still completes (ready is honoured).
  - Nothing is pushed.
  - err_o pulses high in the following cycle.
- Latency: a word accepted in cycle N is visible on inst_o with inst_valid_o=1 in cycle N+1 if the FIFO was empty. There is no combinational request-to-output path.
- Pop when inst_valid_o & inst_ready_i; the head advances the next cycle.
- FIFO is circular; read/write pointers wrap modulo DEPTH.
- Simultaneous push and pop:
  - Occupancy unchanged.
  - Allowed when not full.
  - When full, ready is 0, so only the pop occurs.
- Empty: inst_valid_o=0, inst_o=32'h0, pop ignored.
- flush_i=1:
  - Pointers and count go to 0 on the next edge.
  - A concurrent push or pop is discarded.
  - A concurrent illegal request is not flagged, since ready=0.
- Reset (asserted at any time, including mid-transfer):
  - Immediately: req_ready_o=0, inst_valid_o=0, inst_o=0, count_o=0, err_o=0.
  - After release: req_ready_o=1 in the first cycle.

Optional Feature:
- Macro INST_ENC_ZERO_DST_CHECK_EN.
- Defined: any non-NOP request with dst_i==0 is treated as illegal (err_o pulse, no push).
- Undefined: dst_i==0 is encoded normally.

Test Plan:
- Reset release, then request OR/LOGIC/form 1, src1=1, dst=2, imm=16'h1234 → one cycle later inst_o=32'h34221234, inst_valid_o=1, count_o=1.
- Requests for lui (OR/LOGIC/form 2, dst=3, imm=16'hABCD) then sra (SRA/SHIFT/form 3, src2=4, dst=5, sa=7), with inst_ready_i held 0 → inst_o stays 32'h3C03ABCD. Then assert ready → 32'h000429C3 next, then empty with inst_o=0.
- Push DEPTH requests with inst_ready_i=0 → req_ready_o=0 and count_o=4. Assert push and pop together → only the pop occurs, count_o=3. Then push and pop together for 8 cycles → count stays 3, order preserved across pointer wrap.
- NOR/LOGIC/form 1 and AND/LOGIC/form 2 requests → err_o pulses one cycle after each, count_o unchanged.
- Three entries queued, flush_i pulsed while req_valid_i=1 → count_o=0 and inst_valid_o=0 next cycle, request not accepted. Separately, assert rst mid-stream → outputs 0 immediately.
- With INST_ENC_ZERO_DST_CHECK_EN defined, XOR/LOGIC/form 0 with dst=0 → err_o=1, no push. Without the macro → inst_o=32'h00000026.
